gc_run_controller: RTL and testbench
====================================

Name: gc_run_controller

Overview:
- Sequences repeated garbling runs of GarbledCircuit. Pulses its start input once per run.
- Captures GarbledCircuit's dual-lane tagged output stream (tag/index0/index1/data0/data1).
- Serializes that stream into a single-word valid/ready stream through an internal FIFO. The downstream (host link or MAC) can back-pressure, even though GarbledCircuit itself cannot stall.

Parameters:
- S, 5, index width; matches GarbledCircuit S.
- K, 128, label/key width; matches GarbledCircuit K.
- FD, 6, log2 FIFO depth (64 words); must be at least the largest words-per-run.
- TIMEOUT, 1024, max idle cycles in RUN before an error abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  start a batch; ignored unless state is IDLE
- cfg_runs  in  16  number of runs in the batch; sampled on go
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at batch end
- err  out  1  sticky; set on overflow or timeout; cleared on go
- gc_start  out  1  to GarbledCircuit start
- gc_tag  in  3  from GarbledCircuit tag
- gc_index0, gc_index1  in  S  from GarbledCircuit
- gc_data0, gc_data1  in  K  from GarbledCircuit
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accept
- out_tag  out  3  tag of head word
- out_index  out  S  index of head word
- out_data  out  K  data of head word
- out_last  out  1  head word is a run's output-mask word
- runs_done  out  16  completed runs in current batch

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE. A reset mid-run discards FIFO contents and counters.
- Tag decode, applied every cycle in RUN (tags ignored in all other states):
  - 000 = idle, no words.
  - 1ab = input labels: lane0 word if b=1, lane1 word if a=1.
  - 001 = keys: both lanes.
  - 010 = garbled table rows: both lanes.
  - 011 = output mask: lane0 only; this ends the run.
- FIFO entry is {tag, index, data, last}.
  - Pushes per cycle: 0, 1 or 2. Lane0 is written before lane1.
  - One pop per cycle when out_valid && out_ready.
  - Push and pop in the same cycle are both honoured.
  - Occupancy update = pushes - pop.
  - A word pushed in cycle t is visible at the output no earlier than t+1.
  - out_* hold stable while out_valid && !out_ready.
- Overflow: words exceeding free slots (free slots count the same-cycle pop) are dropped, lane1 first, and err is set. The run continues.
- State machine:
  - IDLE: on go, latch cfg_runs and clear runs_done and err. If cfg_runs==0 go to FIN; else go to START.
  - START: gc_start=1 for exactly one cycle, clear the idle counter, then go to RUN.
  - RUN: the idle counter increments on tag 000 and clears on any other tag.
    - On tag 011: runs_done+1. If runs_done+1==cfg_runs go to DRAIN; else go to GAP.
    - If the idle counter reaches TIMEOUT: set err, go to DRAIN.
  - GAP: wait for FIFO empty, then go to START. Runs are never overlapped.
  - DRAIN: wait for FIFO empty, then go to FIN.
  - FIN: done=1 for one cycle, then go to IDLE.
- busy=1 in START, RUN, GAP, DRAIN and FIN.
- go while busy: no effect.
- runs_done saturates at 0xFFFF and holds its value after done until the next go.

Test Plan:
- Reset, go with cfg_runs=1, GC stream of 21 label words, 2 keys, 16 table rows, 1 mask, out_ready=1 -> exactly one gc_start pulse; 40 words out in stream order; out_last only on word 40 (tag 011); done pulses after the FIFO empties; runs_done=1.
- cfg_runs=3, out_ready toggling 1/0 every cycle -> three gc_start pulses; each pulse occurs only after the FIFO is empty; 120 words total with no loss; err=0; done once.
- Single-lane label tags 101 and 110 interleaved with 111 -> only the enabled lanes are pushed; lane0 precedes lane1 within a cycle.
- out_ready=0 for a whole run of 80 words with FD=6 -> first 64 words retained; err=1; remaining words dropped; run still completes; done after drain.
- GC stalls (tag 000) for 1024 cycles after gc_start -> err=1, DRAIN, done pulse, runs_done=0; a following go clears err.
- rst asserted mid-RUN with 10 words buffered -> next cycle: out_valid=0, busy=0, runs_done=0, err=0; a following go works normally; go with cfg_runs=0 -> done pulses 2 cycles after go with no gc_start.

Source files
------------

// File: rtl/gc_run_controller.sv
// gc_run_controller: sequences GarbledCircuit runs and serializes its dual-lane
// tagged output stream into a single-word valid/ready stream through a FIFO.
module gc_run_controller #(
   parameter int unsigned S       = 5,
   parameter int unsigned K       = 128,
   parameter int unsigned FD      = 6,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          go,
   input  logic [15:0]   cfg_runs,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          gc_start,
   input  logic [2:0]    gc_tag,
   input  logic [S-1:0]  gc_index0,
   input  logic [S-1:0]  gc_index1,
   input  logic [K-1:0]  gc_data0,
   input  logic [K-1:0]  gc_data1,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [2:0]    out_tag,
   output logic [S-1:0]  out_index,
   output logic [K-1:0]  out_data,
   output logic          out_last,
   output logic [15:0]   runs_done
);

   localparam int unsigned EW    = 3 + S + K + 1;
   localparam int unsigned DEPTH = 1 << FD;
   localparam int unsigned CW    = FD + 1;
   localparam int unsigned TW    = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_RUN, ST_GAP, ST_DRAIN, ST_FIN
   } state_t;

   state_t          state_q;
   logic            busy_q, done_q, err_q, gc_start_q;
   logic [15:0]     cfg_q, runs_q;
   logic [TW-1:0]   idle_q;

   logic [EW-1:0]   mem_q [DEPTH];
   logic [FD-1:0]   wr_q, rd_q;
   logic [CW-1:0]   cnt_q;

   logic            in_run, req0, req1, push0, push1, pop, drop;
   logic [CW-1:0]   free_slots, cnt_d;
   logic [FD-1:0]   wr1;
   logic [EW-1:0]   lane0_w, lane1_w, head;
   logic [16:0]     runs_inc;

   // Tag decode, overflow arbitration (lane1 dropped first) and FIFO bookkeeping
   always_comb begin
      in_run     = (state_q == ST_RUN);
      req0       = 1'b0;
      req1       = 1'b0;
      if (in_run) begin
         unique case (gc_tag)
            3'b000:                   begin req0 = 1'b0;      req1 = 1'b0;      end
            3'b001, 3'b010:           begin req0 = 1'b1;      req1 = 1'b1;      end
            3'b011:                   begin req0 = 1'b1;      req1 = 1'b0;      end
            default:                  begin req0 = gc_tag[0]; req1 = gc_tag[1]; end
         endcase
      end
      pop        = (cnt_q != '0) && out_ready;
      free_slots = CW'(DEPTH) - cnt_q + CW'(pop);
      push0      = req0 && (free_slots != '0);
      push1      = req1 && (free_slots > CW'(push0));
      drop       = (req0 && !push0) || (req1 && !push1);
      wr1        = wr_q + FD'(push0);
      cnt_d      = cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
      lane0_w    = {gc_tag, gc_index0, gc_data0, (gc_tag == 3'b011)};
      lane1_w    = {gc_tag, gc_index1, gc_data1, 1'b0};
      runs_inc   = {1'b0, runs_q} + 17'd1;
   end

   // FIFO storage; only free slots are written so the head word never changes under back-pressure
   always_ff @(posedge clk) begin
      if (push0) mem_q[wr_q] <= lane0_w;
      if (push1) mem_q[wr1]  <= lane1_w;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + FD'(push0) + FD'(push1);
         rd_q  <= rd_q + FD'(pop);
         cnt_q <= cnt_d;
      end
   end

   // Batch sequencer with registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         gc_start_q <= 1'b0;
         cfg_q      <= '0;
         runs_q     <= '0;
         idle_q     <= '0;
      end else begin
         gc_start_q <= 1'b0;
         done_q     <= 1'b0;
         if (drop) err_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (go) begin
                  cfg_q  <= cfg_runs;
                  runs_q <= '0;
                  err_q  <= 1'b0;
                  busy_q <= 1'b1;
                  if (cfg_runs == '0) begin
                     state_q <= ST_FIN;
                  end else begin
                     state_q    <= ST_START;
                     gc_start_q <= 1'b1;
                  end
               end
            end
            ST_START: begin
               idle_q  <= '0;
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (gc_tag == 3'b011) begin
                  idle_q <= '0;
                  runs_q <= (runs_q == 16'hFFFF) ? runs_q : runs_inc[15:0];
                  state_q <= (runs_inc == {1'b0, cfg_q}) ? ST_DRAIN : ST_GAP;
               end else if (gc_tag == 3'b000) begin
                  if (idle_q == TW'(TIMEOUT - 1)) begin
                     err_q   <= 1'b1;
                     state_q <= ST_DRAIN;
                  end else begin
                     idle_q <= idle_q + TW'(1);
                  end
               end else begin
                  idle_q <= '0;
               end
            end
            ST_GAP: begin
               if (cnt_q == '0) begin
                  state_q    <= ST_START;
                  gc_start_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (cnt_q == '0) state_q <= ST_FIN;
            end
            ST_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Head word is zeroed while the FIFO is empty so idle outputs read as 0
   always_comb begin
      head      = mem_q[rd_q];
      out_valid = (cnt_q != '0);
      out_tag   = out_valid ? head[EW-1 -: 3] : '0;
      out_index = out_valid ? head[EW-4 -: S] : '0;
      out_data  = out_valid ? head[K:1]       : '0;
      out_last  = out_valid & head[0];
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign gc_start  = gc_start_q;
   assign runs_done = runs_q;

endmodule

// File: tb/tb_gc_run_controller.sv
// Directed testbench for gc_run_controller.
module tb_gc_run_controller;

   localparam int unsigned S  = 5;
   localparam int unsigned K  = 128;
   localparam int unsigned EW = 3 + S + K + 1;

   logic          clk = 1'b0;
   logic          rst, go;
   logic [15:0]   cfg_runs;
   logic          busy, done, err, gc_start;
   logic [2:0]    gc_tag;
   logic [S-1:0]  gc_index0, gc_index1;
   logic [K-1:0]  gc_data0, gc_data1;
   logic          out_valid, out_ready;
   logic [2:0]    out_tag;
   logic [S-1:0]  out_index;
   logic [K-1:0]  out_data;
   logic          out_last;
   logic [15:0]   runs_done;

   logic          rdy_fixed, tog_en, tog_q;
   int            n_tests = 0, n_fail = 0;
   int            n_start = 0, n_bad_start = 0, n_done = 0;
   int            seq = 0, snap_start, snap_done;
   bit            cap_mode = 1'b0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] act_q[$];

   gc_run_controller #(.S(S), .K(K), .FD(6), .TIMEOUT(1024)) dut (
      .clk(clk), .rst(rst), .go(go), .cfg_runs(cfg_runs),
      .busy(busy), .done(done), .err(err), .gc_start(gc_start),
      .gc_tag(gc_tag), .gc_index0(gc_index0), .gc_index1(gc_index1),
      .gc_data0(gc_data0), .gc_data1(gc_data1),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .out_index(out_index), .out_data(out_data), .out_last(out_last),
      .runs_done(runs_done)
   );

   always #5 clk = ~clk;

   assign out_ready = tog_en ? tog_q : rdy_fixed;

   always @(posedge clk) tog_q <= ~tog_q;

   // Record accepted output words and start/done pulses
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) act_q.push_back({out_tag, out_index, out_data, out_last});
         if (gc_start) begin
            n_start++;
            if (out_valid) n_bad_start++;
         end
         if (done) n_done++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One GC output cycle; e0/e1 are the hand-decoded lanes that must reach the FIFO
   task automatic gc_cycle(input logic [2:0] t, input bit e0, input bit e1, input bit lst);
      logic [EW-1:0] w0, w1;
      gc_tag    = t;
      gc_index0 = S'(seq);
      gc_index1 = S'(seq + 16);
      gc_data0  = {64'(seq), 64'hD0D0_0000_0000_0000};
      gc_data1  = {64'(seq), 64'hD1D1_0000_0000_0000};
      w0 = {t, gc_index0, gc_data0, lst};
      w1 = {t, gc_index1, gc_data1, 1'b0};
      if (e0 && !(cap_mode && exp_q.size() >= 64)) exp_q.push_back(w0);
      if (e1 && !(cap_mode && exp_q.size() >= 64)) exp_q.push_back(w1);
      @(posedge clk); #1;
      seq++;
      gc_tag = 3'b000;
   endtask

   task automatic std_run();
      for (int i = 0; i < 10; i++) gc_cycle(3'b111, 1, 1, 0);
      gc_cycle(3'b101, 1, 0, 0);
      gc_cycle(3'b001, 1, 1, 0);
      for (int i = 0; i < 8; i++) gc_cycle(3'b010, 1, 1, 0);
      gc_cycle(3'b011, 1, 0, 1);
   endtask

   task automatic go_run(input logic [15:0] n);
      go = 1'b1;
      cfg_runs = n;
      @(posedge clk); #1;
      go = 1'b0;
   endtask

   // Returns positioned in the first RUN cycle
   task automatic wait_start(input string tag);
      int i = 0;
      while (!gc_start && i < 300) begin @(posedge clk); #1; i++; end
      chk(tag, EW'(gc_start), EW'(1));
      @(posedge clk); #1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int i = 0;
      while (!done && i < budget) begin @(posedge clk); #1; i++; end
      chk(tag, EW'(done), EW'(1));
   endtask

   task automatic check_stream(input string tag);
      int n;
      chk({tag, "_len"}, EW'(act_q.size()), EW'(exp_q.size()));
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), act_q[i], exp_q[i]);
      act_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; cfg_runs = '0; gc_tag = '0;
      gc_index0 = '0; gc_index1 = '0; gc_data0 = '0; gc_data1 = '0;
      rdy_fixed = 1'b1; tog_en = 1'b0; tog_q = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Reset state
      chk("rst_busy", EW'(busy), EW'(0));
      chk("rst_done", EW'(done), EW'(0));
      chk("rst_err", EW'(err), EW'(0));
      chk("rst_gc_start", EW'(gc_start), EW'(0));
      chk("rst_out_valid", EW'(out_valid), EW'(0));
      chk("rst_out_word", {out_tag, out_index, out_data, out_last}, EW'(0));
      chk("rst_runs_done", EW'(runs_done), EW'(0));

      // Single 40-word run with free-flowing output
      snap_start = n_start; snap_done = n_done;
      go_run(16'd1);
      chk("t1_busy", EW'(busy), EW'(1));
      wait_start("t1_start");
      std_run();
      wait_done("t1_done", 200);
      chk("t1_empty_at_done", EW'(out_valid), EW'(0));
      chk("t1_runs_done", EW'(runs_done), EW'(1));
      chk("t1_n_start", EW'(n_start - snap_start), EW'(1));
      chk("t1_err", EW'(err), EW'(0));
      check_stream("t1");
      @(posedge clk); #1;
      chk("t1_done_pulse", EW'(n_done - snap_done), EW'(1));
      chk("t1_idle", EW'(busy), EW'(0));

      // Three runs with toggling back-pressure
      snap_start = n_start; snap_done = n_done;
      tog_en = 1'b1;
      go_run(16'd3);
      for (int r = 0; r < 3; r++) begin
         wait_start($sformatf("t2_start%0d", r));
         std_run();
      end
      wait_done("t2_done", 400);
      tog_en = 1'b0;
      chk("t2_runs_done", EW'(runs_done), EW'(3));
      chk("t2_n_start", EW'(n_start - snap_start), EW'(3));
      chk("t2_start_nonempty", EW'(n_bad_start), EW'(0));
      chk("t2_err", EW'(err), EW'(0));
      check_stream("t2");
      @(posedge clk); #1;
      chk("t2_done_pulse", EW'(n_done - snap_done), EW'(1));

      // Single-lane label tags
      go_run(16'd1);
      wait_start("t3_start");
      gc_cycle(3'b111, 1, 1, 0);
      gc_cycle(3'b101, 1, 0, 0);
      gc_cycle(3'b110, 0, 1, 0);
      gc_cycle(3'b111, 1, 1, 0);
      gc_cycle(3'b110, 0, 1, 0);
      gc_cycle(3'b101, 1, 0, 0);
      gc_cycle(3'b011, 1, 0, 1);
      wait_done("t3_done", 200);
      check_stream("t3");

      // Overflow with output fully stalled: 80 words into a 64-deep FIFO
      rdy_fixed = 1'b0;
      cap_mode  = 1'b1;
      go_run(16'd1);
      wait_start("t4_start");
      for (int i = 0; i < 32; i++) gc_cycle(3'b111, 1, 1, 0);
      chk("t4_err_at_full", EW'(err), EW'(0));
      for (int i = 0; i < 7; i++) gc_cycle(3'b111, 1, 1, 0);
      gc_cycle(3'b101, 1, 0, 0);
      gc_cycle(3'b011, 1, 0, 1);
      chk("t4_err", EW'(err), EW'(1));
      chk("t4_runs_done", EW'(runs_done), EW'(1));
      chk("t4_still_busy", EW'(busy), EW'(1));
      rdy_fixed = 1'b1;
      wait_done("t4_done", 300);
      cap_mode = 1'b0;
      check_stream("t4");

      // Timeout abort, then a following go clears err
      snap_done = n_done;
      go_run(16'd1);
      wait_start("t5_start");
      repeat (1000) @(posedge clk);
      #1;
      chk("t5_err_before_timeout", EW'(err), EW'(0));
      wait_done("t5_done", 200);
      chk("t5_err", EW'(err), EW'(1));
      chk("t5_runs_done", EW'(runs_done), EW'(0));
      go_run(16'd1);
      chk("t5_err_cleared", EW'(err), EW'(0));
      wait_start("t5b_start");
      gc_cycle(3'b111, 1, 1, 0);
      gc_cycle(3'b011, 1, 0, 1);
      wait_done("t5b_done", 200);
      chk("t5b_err", EW'(err), EW'(0));
      check_stream("t5b");

      // Reset in the middle of a second run with 10 words buffered
      go_run(16'd2);
      wait_start("t6_start0");
      gc_cycle(3'b111, 1, 1, 0);
      gc_cycle(3'b011, 1, 0, 1);
      wait_start("t6_start1");
      check_stream("t6a");
      rdy_fixed = 1'b0;
      for (int i = 0; i < 5; i++) gc_cycle(3'b111, 1, 1, 0);
      chk("t6_buffered", EW'(out_valid), EW'(1));
      chk("t6_runs_before", EW'(runs_done), EW'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t6_out_valid", EW'(out_valid), EW'(0));
      chk("t6_busy", EW'(busy), EW'(0));
      chk("t6_runs_done", EW'(runs_done), EW'(0));
      chk("t6_err", EW'(err), EW'(0));
      exp_q.delete();
      act_q.delete();
      rdy_fixed = 1'b1;
      go_run(16'd1);
      wait_start("t6b_start");
      std_run();
      wait_done("t6b_done", 200);
      chk("t6b_runs_done", EW'(runs_done), EW'(1));
      check_stream("t6b");
      @(posedge clk); #1;

      // Zero-run batch
      snap_start = n_start;
      go_run(16'd0);
      chk("t7_done_early", EW'(done), EW'(0));
      chk("t7_busy", EW'(busy), EW'(1));
      @(posedge clk); #1;
      chk("t7_done", EW'(done), EW'(1));
      chk("t7_idle", EW'(busy), EW'(0));
      chk("t7_no_start", EW'(n_start - snap_start), EW'(0));
      chk("t7_runs_done", EW'(runs_done), EW'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
